// File: rtl/xilly_fifo_drain_if.sv
// Handshake bundle between the drain block, the upstream sync FIFO read port
// and the downstream valid/ready consumer.
//   fifo_dout  [31:0]  FIFO read data, valid one cycle after an accepted read
//   fifo_empty         FIFO empty flag
//   fifo_rd_en         FIFO read strobe
//   m_data     [31:0]  output stream data
//   m_valid            output data valid
//   m_ready            downstream accepts the current word
//   m_last             final word of a packet
// master: the drain block. slave: the FIFO plus the downstream consumer.
interface xilly_fifo_drain_if;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (
        input  fifo_dout, fifo_empty, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_dout, fifo_empty, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/xilly_fifo_drain.sv
// Drains a standard (non-FWFT) 32-bit sync FIFO into a valid/ready stream
// through a 4-entry elastic buffer, and frames the stream into PKT_LEN-word
// packets with a last flag and a wrapping packet counter.
//
// Ports:
//   clk        system clock, shared with the FIFO
//   rst        synchronous active-high reset
//   bus        handshake bundle (xilly_fifo_drain_if.master)
//   pkt_count  completed packets since reset, wraps at 2^CNT_W
//   busy       buffer non-empty or a FIFO read in flight
//
// Optional feature, macro XILLY_DRAIN_CHECKSUM_EN:
//   pkt_csum      XOR of all words of the last completed packet
//   pkt_csum_vld  one-cycle strobe, the cycle after the last word transfers
module xilly_fifo_drain #(
    parameter int PKT_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    xilly_fifo_drain_if.master   bus,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 busy
`ifdef XILLY_DRAIN_CHECKSUM_EN
    ,
    output logic [31:0]          pkt_csum,
    output logic                 pkt_csum_vld
`endif
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic [31:0]      r_mem [4];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_occ;
    logic             r_infl;
    logic [15:0]      r_widx;
    logic [CNT_W-1:0] r_pkt_count;

    logic             w_credit_ok;
    logic             w_rd_en;
    logic             w_valid;
    logic             w_last;
    logic             w_xfer;

    // A read is only issued when the word it returns is guaranteed a slot,
    // counting the word already in flight. This keeps m_ready off the read path.
    assign w_credit_ok = ({1'b0, r_occ} + {3'b000, r_infl}) < 4'd4;
    assign w_rd_en     = ~rst & ~bus.fifo_empty & w_credit_ok;
    assign w_valid     = (r_occ != 3'd0);
    assign w_last      = (r_widx == LAST_IDX) & w_valid;
    assign w_xfer      = w_valid & bus.m_ready;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = r_mem[r_rd_ptr];
    assign bus.m_last     = w_last;
    assign busy           = w_valid | r_infl;
    assign pkt_count      = r_pkt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 32'd0;
            end
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_occ       <= 3'd0;
            r_infl      <= 1'b0;
            r_widx      <= 16'd0;
            r_pkt_count <= '0;
        end else begin
            r_infl <= w_rd_en;

            // FIFO dout is only valid for the cycle after the read, so the
            // in-flight word is captured unconditionally; credit ensures room.
            if (r_infl) begin
                r_mem[r_wr_ptr] <= bus.fifo_dout;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end

            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                if (w_last) begin
                    r_widx      <= 16'd0;
                    r_pkt_count <= r_pkt_count + CNT_W'(1);
                end else begin
                    r_widx <= r_widx + 16'd1;
                end
            end

            r_occ <= r_occ + {2'b00, r_infl} - {2'b00, w_xfer};
        end
    end

`ifdef XILLY_DRAIN_CHECKSUM_EN
    logic [31:0] r_csum_acc;
    logic [31:0] r_pkt_csum;
    logic        r_pkt_csum_vld;

    assign pkt_csum     = r_pkt_csum;
    assign pkt_csum_vld = r_pkt_csum_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum_acc     <= 32'd0;
            r_pkt_csum     <= 32'd0;
            r_pkt_csum_vld <= 1'b0;
        end else begin
            r_pkt_csum_vld <= 1'b0;
            if (w_xfer) begin
                if (w_last) begin
                    // Fold the last word in directly and restart for the next packet.
                    r_pkt_csum     <= r_csum_acc ^ bus.m_data;
                    r_pkt_csum_vld <= 1'b1;
                    r_csum_acc     <= 32'd0;
                end else begin
                    r_csum_acc <= r_csum_acc ^ bus.m_data;
                end
            end
        end
    end
`endif

endmodule
